board_row_fetcher: RTL and testbench
====================================

// Module: board_row_fetcher
// PURPOSE
//  Upstream feeder for the colour mapper. On each row request it reads one board row (BOARD_W cells)
//  from the board RAM, overlays the falling tetromino, and commits the assembled row to Row[].
//  Row[] stays stable between commits, so the mapper always draws a complete row.
// PARAMETERS
//  BOARD_W  10  cells per board row
//  BOARD_H  20  board rows; valid rowNum is 0..BOARD_H-1
//  CELL_W   16  bits per cell: [15:12]=0, [11:0]=RGB444; 0 = empty cell
//  ADDR_W   8   board RAM address width; address = row*BOARD_W + col
// PORTS
//  Clk          in   1           system clock
//  reset        in   1           synchronous, active-high
//  LD_Row       in   1           row request; level, may be held many cycles
//  rowNum       in   8           requested board row, sampled on the LD_Row rising edge
//  piece_valid  in   1           falling piece present
//  piece_x      in   4 x [4]     column of each of the 4 piece blocks
//  piece_y      in   5 x [4]     row of each of the 4 piece blocks
//  piece_color  in   12          RGB444 colour of the falling piece
//  ram_re       out  1           board RAM read enable
//  ram_addr     out  ADDR_W      board RAM address
//  ram_rdata    in   CELL_W      board RAM data, valid 1 cycle after ram_re/ram_addr
//  Row          out  CELL_W x [BOARD_W]  committed row to the mapper
//  rowReady     out  1           1-cycle pulse on the cycle Row[] changes
//  busy         out  1           high in any state other than IDLE
//  overrun      out  1           sticky: a request arrived while busy; cleared only by reset
// BEHAVIOUR
//  - Clock/reset: one clock, Clk. reset is synchronous and active-high.
//  - Reset (including mid-fetch): state=IDLE; Row[*]=0; rowReady=0; ram_re=0; ram_addr=0;
//    busy=0; overrun=0; LD_Row edge register=0; read/write counters=0.
//  - Request detection: req = LD_Row & ~LD_Row_q, where LD_Row_q is a 1-cycle delayed copy.
//    Holding LD_Row high gives exactly one request.
//  - On req in IDLE, latch these as the fetch snapshot: rowNum, piece_valid, piece_x, piece_y,
//    piece_color. Mid-fetch changes to these inputs have no effect.
//  - FSM IDLE -> READ -> DRAIN -> COMMIT -> IDLE.
//  - IDLE: ram_re=0. On req with rowNum<BOARD_H, go to READ with rd_col=0.
//    If rowNum>=BOARD_H, go straight to COMMIT with the shadow buffer zeroed; no RAM reads.
//  - READ: ram_re=1, ram_addr=latched_row*BOARD_W+rd_col (ADDR_W bits, no wrap at defaults).
//    rd_col increments each cycle. After rd_col=BOARD_W-1 is issued, go to DRAIN.
//  - Data capture (READ and DRAIN): a cell is written to shadow[c] 1 cycle after its address
//    was issued. The value written is:
//      {4'h0, piece_color}  if piece_valid and any i has piece_x[i]==c and piece_y[i]==latched_row;
//      ram_rdata            otherwise.
//  - DRAIN: lasts 1 cycle and captures the last cell. Then go to COMMIT.
//  - COMMIT: Row[*] <= shadow[*] and rowReady pulses on the same edge (registered). Back to IDLE.
//  - Latency for a valid row: req cycle T; first ram_re at T+1; rowReady high at T+BOARD_W+3
//    (T+13 at defaults). Out-of-range row: rowReady at T+2.
//  - req while busy is dropped: no restart, current fetch continues, overrun<=1.
//    A req in the same cycle as COMMIT also counts as busy.
//  - Row[] holds its last committed value at all times except the COMMIT edge and reset.
// TESTING
//  T1: RAM cell(r,c)=16'h0100*r+c. Pulse LD_Row with rowNum=3 -> addrs 30..39 on consecutive
//      cycles; rowReady at T+13; Row[c]=16'h0300+c.
//  T2: Hold LD_Row high 200 cycles with rowNum=5 -> exactly one fetch, one rowReady, overrun=0.
//  T3: Piece at (x=2,y=7),(3,7),(4,7),(4,8), colour 12'hF00, row 7 fetched -> Row[2..4]=16'h0F00,
//      other cells from RAM. Change piece_color at T+4 -> still 16'h0F00.
//  T4: rowNum=25 -> no ram_re; rowReady at T+2; Row[*]=0.
//  T5: Second LD_Row edge at T+5 -> first fetch completes unchanged; overrun=1 until reset.
//  T6: Assert reset at T+6 of a fetch -> next cycle Row[*]=0, ram_re=0, busy=0, no rowReady.
//      A later request then fetches normally.

Source files
------------

// File: rtl/board_row_fetcher.sv
// Fetches one board row from the board RAM, overlays the falling tetromino and commits the
// assembled row to Row[] in one edge, so the colour mapper never sees a partially built row.
module board_row_fetcher #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int CELL_W  = 16,
    parameter int ADDR_W  = 8
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              LD_Row,
    input  logic [7:0]        rowNum,
    input  logic              piece_valid,
    input  logic [3:0]        piece_x [4],
    input  logic [4:0]        piece_y [4],
    input  logic [11:0]       piece_color,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [CELL_W-1:0] ram_rdata,
    output logic [CELL_W-1:0] Row [BOARD_W],
    output logic              rowReady,
    output logic              busy,
    output logic              overrun,
    output logic [1:0]        dbg_state
);

    localparam int COL_W = (BOARD_W > 1) ? $clog2(BOARD_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_READ   = 2'd1,
        S_DRAIN  = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t            state_q, state_d;

    logic              ld_row_q, ld_row_d;
    logic              req;
    logic              row_in_range;

    // Fetch snapshot: frozen on the accepted request so mid-fetch input changes are ignored.
    logic [7:0]        snap_row_q, snap_row_d;
    logic              snap_valid_q, snap_valid_d;
    logic [3:0]        snap_x_q [4];
    logic [3:0]        snap_x_d [4];
    logic [4:0]        snap_y_q [4];
    logic [4:0]        snap_y_d [4];
    logic [11:0]       snap_color_q, snap_color_d;

    logic [COL_W-1:0]  rd_col_q, rd_col_d;
    logic              cap_valid_q, cap_valid_d;
    logic [COL_W-1:0]  cap_col_q, cap_col_d;
    logic              cap_hit;

    logic [CELL_W-1:0] shadow_q [BOARD_W];
    logic [CELL_W-1:0] shadow_d [BOARD_W];
    logic [CELL_W-1:0] row_q [BOARD_W];
    logic [CELL_W-1:0] row_d [BOARD_W];

    logic              row_ready_q, row_ready_d;
    logic              overrun_q, overrun_d;
    logic [ADDR_W-1:0] rd_addr;

    assign req          = LD_Row & ~ld_row_q;
    assign row_in_range = (rowNum < 8'(BOARD_H));
    assign rd_addr      = ADDR_W'(snap_row_q) * ADDR_W'(BOARD_W) + ADDR_W'(rd_col_q);

    // ---------------------------------------------------------------- state register
    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = row_in_range ? S_READ : S_COMMIT;
                end
            end
            S_READ: begin
                if (rd_col_q == COL_W'(BOARD_W - 1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN:  state_d = S_COMMIT;
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        ram_re    = 1'b0;
        ram_addr  = '0;
        busy      = (state_q != S_IDLE);
        dbg_state = state_q;
        if (state_q == S_READ) begin
            ram_re   = 1'b1;
            ram_addr = rd_addr;
        end
    end

    assign Row      = row_q;
    assign rowReady = row_ready_q;
    assign overrun  = overrun_q;

    // Overlay test for the cell whose RAM data arrives this cycle.
    always_comb begin
        cap_hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if ((8'(snap_x_q[i]) == 8'(cap_col_q)) && (8'(snap_y_q[i]) == snap_row_q)) begin
                cap_hit = 1'b1;
            end
        end
        cap_hit = cap_hit & snap_valid_q;
    end

    // ---------------------------------------------------------------- datapath next values
    always_comb begin
        ld_row_d     = LD_Row;
        snap_row_d   = snap_row_q;
        snap_valid_d = snap_valid_q;
        snap_x_d     = snap_x_q;
        snap_y_d     = snap_y_q;
        snap_color_d = snap_color_q;
        rd_col_d     = rd_col_q;
        shadow_d     = shadow_q;
        row_d        = row_q;
        row_ready_d  = 1'b0;
        overrun_d    = overrun_q;
        cap_valid_d  = (state_q == S_READ);
        cap_col_d    = rd_col_q;

        if (req && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        if ((state_q == S_IDLE) && req) begin
            snap_row_d   = rowNum;
            snap_valid_d = piece_valid;
            snap_x_d     = piece_x;
            snap_y_d     = piece_y;
            snap_color_d = piece_color;
            rd_col_d     = '0;
            if (!row_in_range) begin
                for (int c = 0; c < BOARD_W; c++) begin
                    shadow_d[c] = '0;
                end
            end
        end

        if (state_q == S_READ) begin
            rd_col_d = (rd_col_q == COL_W'(BOARD_W - 1)) ? '0 : rd_col_q + 1'b1;
        end

        // RAM data lags its address by one cycle, so capture runs through READ and DRAIN.
        for (int c = 0; c < BOARD_W; c++) begin
            if (cap_valid_q && (cap_col_q == COL_W'(c))) begin
                shadow_d[c] = cap_hit ? CELL_W'(snap_color_q) : ram_rdata;
            end
        end

        if (state_q == S_COMMIT) begin
            row_d       = shadow_q;
            row_ready_d = 1'b1;
        end
    end

    // ---------------------------------------------------------------- datapath registers
    always_ff @(posedge Clk) begin
        if (reset) begin
            ld_row_q     <= 1'b0;
            snap_row_q   <= '0;
            snap_valid_q <= 1'b0;
            snap_color_q <= '0;
            rd_col_q     <= '0;
            cap_valid_q  <= 1'b0;
            cap_col_q    <= '0;
            row_ready_q  <= 1'b0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                snap_x_q[i] <= '0;
                snap_y_q[i] <= '0;
            end
            for (int c = 0; c < BOARD_W; c++) begin
                shadow_q[c] <= '0;
                row_q[c]    <= '0;
            end
        end else begin
            ld_row_q     <= ld_row_d;
            snap_row_q   <= snap_row_d;
            snap_valid_q <= snap_valid_d;
            snap_color_q <= snap_color_d;
            rd_col_q     <= rd_col_d;
            cap_valid_q  <= cap_valid_d;
            cap_col_q    <= cap_col_d;
            row_ready_q  <= row_ready_d;
            overrun_q    <= overrun_d;
            for (int i = 0; i < 4; i++) begin
                snap_x_q[i] <= snap_x_d[i];
                snap_y_q[i] <= snap_y_d[i];
            end
            for (int c = 0; c < BOARD_W; c++) begin
                shadow_q[c] <= shadow_d[c];
                row_q[c]    <= row_d[c];
            end
        end
    end

endmodule

// File: tb/tb_board_row_fetcher.sv
// Directed bench for board_row_fetcher: a behavioural board RAM holding 16'h0100*row+col,
// per-cycle logs of the RAM port and handshake outputs, and immediate-assertion checks.
module tb_board_row_fetcher;

    logic        Clk;
    logic        reset;
    logic        LD_Row;
    logic [7:0]  rowNum;
    logic        piece_valid;
    logic [3:0]  piece_x [4];
    logic [4:0]  piece_y [4];
    logic [11:0] piece_color;
    logic        ram_re;
    logic [7:0]  ram_addr;
    logic [15:0] ram_rdata;
    logic [15:0] row_out [10];
    logic        rowReady;
    logic        busy;
    logic        overrun;
    logic [1:0]  dbg_state;

    int tests;
    int failed;

    logic        re_log   [256];
    logic [7:0]  addr_log [256];
    logic        rdy_log  [256];
    logic        busy_log [256];
    logic [15:0] exp_row  [10];

    board_row_fetcher dut (
        .Clk         (Clk),
        .reset       (reset),
        .LD_Row      (LD_Row),
        .rowNum      (rowNum),
        .piece_valid (piece_valid),
        .piece_x     (piece_x),
        .piece_y     (piece_y),
        .piece_color (piece_color),
        .ram_re      (ram_re),
        .ram_addr    (ram_addr),
        .ram_rdata   (ram_rdata),
        .Row         (row_out),
        .rowReady    (rowReady),
        .busy        (busy),
        .overrun     (overrun),
        .dbg_state   (dbg_state)
    );

    // ------------------------------------------------------------ clock
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ------------------------------------------------------------ board RAM model
    function automatic logic [15:0] ram_cell(input int a);
        return 16'((a / 10) * 256 + (a % 10));
    endfunction

    initial ram_rdata = '0;
    always @(posedge Clk) begin
        if (ram_re) ram_rdata <= ram_cell(int'(ram_addr));
    end

    // ------------------------------------------------------------ checking
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_row(input string tag);
        for (int c = 0; c < 10; c++) begin
            check($sformatf("%s_row%0d", tag, c), 32'(row_out[c]), 32'(exp_row[c]));
        end
    endtask

    task automatic set_exp_ram_row(input int r);
        for (int c = 0; c < 10; c++) exp_row[c] = ram_cell(r * 10 + c);
    endtask

    // Expect ram_re on cycles 1..re_last (addresses base..), busy on 1..busy_last, rowReady only at rdy_k.
    task automatic check_log(input string tag, input int ncyc, input int base,
                             input int re_last, input int busy_last, input int rdy_k);
        for (int k = 0; k < ncyc; k++) begin
            logic exp_re;
            exp_re = (k >= 1) && (k <= re_last);
            check($sformatf("%s_re_k%0d", tag, k), 32'(re_log[k]), 32'(exp_re));
            if (exp_re) check($sformatf("%s_addr_k%0d", tag, k), 32'(addr_log[k]), 32'(base + k - 1));
            check($sformatf("%s_busy_k%0d", tag, k), 32'(busy_log[k]), 32'((k >= 1) && (k <= busy_last)));
            check($sformatf("%s_rdy_k%0d", tag, k), 32'(rdy_log[k]), 32'(k == rdy_k));
        end
    endtask

    // ------------------------------------------------------------ driver tasks
    task automatic start_req(input logic [7:0] r);
        @(posedge Clk);
        #1;
        rowNum = r;
        LD_Row = 1'b1;
    endtask

    // Logs cycles T..T+ncyc-1 at the falling edge; hook 1 recolours the piece, 2 re-raises LD_Row,
    // 3 pulses reset.
    task automatic observe(input int ncyc, input int drop_k, input int hook_k, input int hook);
        for (int k = 0; k < ncyc; k++) begin
            @(negedge Clk);
            re_log[k]   = ram_re;
            addr_log[k] = ram_addr;
            rdy_log[k]  = rowReady;
            busy_log[k] = busy;
            if (k == drop_k) LD_Row = 1'b0;
            if (k == hook_k) begin
                case (hook)
                    1: piece_color = 12'h0AB;
                    2: LD_Row = 1'b1;
                    3: reset = 1'b1;
                    default: ;
                endcase
            end
            if ((hook == 3) && (k == hook_k + 1)) reset = 1'b0;
        end
    endtask

    // ------------------------------------------------------------ directed sequence
    initial begin
        tests       = 0;
        failed      = 0;
        reset       = 1'b1;
        LD_Row      = 1'b0;
        rowNum      = '0;
        piece_valid = 1'b0;
        piece_color = '0;
        for (int i = 0; i < 4; i++) begin
            piece_x[i] = '0;
            piece_y[i] = '0;
        end

        // Reset state
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_ram_re", 32'(ram_re), 32'h0);
        check("rst_ram_addr", 32'(ram_addr), 32'h0);
        check("rst_rowReady", 32'(rowReady), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_state", 32'(dbg_state), 32'h0);
        for (int c = 0; c < 10; c++) exp_row[c] = '0;
        check_row("rst");
        @(posedge Clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge Clk);

        // T1: plain fetch of row 3
        start_req(8'd3);
        observe(20, 1, -1, 0);
        check_log("t1", 20, 30, 10, 12, 13);
        set_exp_ram_row(3);
        check_row("t1");
        check("t1_overrun", 32'(overrun), 32'h0);

        // T2: LD_Row held for 200 cycles gives a single fetch
        start_req(8'd5);
        observe(200, -1, -1, 0);
        check_log("t2", 200, 50, 10, 12, 13);
        set_exp_ram_row(5);
        check_row("t2");
        check("t2_overrun", 32'(overrun), 32'h0);
        LD_Row = 1'b0;
        repeat (3) @(posedge Clk);

        // T3: piece overlay on row 7, colour changed mid-fetch
        piece_valid = 1'b1;
        piece_color = 12'hF00;
        piece_x[0] = 4'd2; piece_y[0] = 5'd7;
        piece_x[1] = 4'd3; piece_y[1] = 5'd7;
        piece_x[2] = 4'd4; piece_y[2] = 5'd7;
        piece_x[3] = 4'd4; piece_y[3] = 5'd8;
        start_req(8'd7);
        observe(20, 1, 4, 1);
        check_log("t3", 20, 70, 10, 12, 13);
        set_exp_ram_row(7);
        for (int c = 2; c <= 4; c++) exp_row[c] = 16'h0F00;
        check_row("t3");

        // T3b: same coordinates but no piece present
        piece_valid = 1'b0;
        piece_color = 12'hF00;
        start_req(8'd7);
        observe(20, 1, -1, 0);
        set_exp_ram_row(7);
        check_row("t3b");

        // T4: out-of-range row commits zeros without touching RAM
        start_req(8'd25);
        observe(10, 1, -1, 0);
        check_log("t4", 10, 0, 0, 1, 2);
        for (int c = 0; c < 10; c++) exp_row[c] = '0;
        check_row("t4");

        // T5: second request mid-fetch is dropped and flags overrun
        start_req(8'd3);
        observe(30, 1, 5, 2);
        check_log("t5", 30, 30, 10, 12, 13);
        set_exp_ram_row(3);
        check_row("t5");
        check("t5_overrun", 32'(overrun), 32'h1);
        LD_Row = 1'b0;
        repeat (5) @(posedge Clk);
        @(negedge Clk);
        check("t5_overrun_sticky", 32'(overrun), 32'h1);

        // T6: reset during a fetch clears everything, no commit
        start_req(8'd9);
        observe(20, 1, 6, 3);
        check_log("t6", 20, 90, 6, 6, -1);
        for (int c = 0; c < 10; c++) exp_row[c] = '0;
        check_row("t6");
        check("t6_overrun", 32'(overrun), 32'h0);

        // T6b: normal fetch after the reset
        start_req(8'd11);
        observe(20, 1, -1, 0);
        check_log("t6b", 20, 110, 10, 12, 13);
        set_exp_ram_row(11);
        check_row("t6b");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
